// File: rtl/alu_input_ctrl_if.sv
// ALU input conditioning bus: raw switch/button levels in,
// registered operand and enable pulses out.
interface alu_input_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int N_BTN   = 3
);
  logic [NB_DATA-1:0] i_sw;
  logic [N_BTN-1:0]   i_btn;
  logic [NB_DATA-1:0] o_data;
  logic               o_enable_1;
  logic               o_enable_2;
  logic               o_enable_3;

  modport master (
    output i_sw,
    output i_btn,
    input  o_data,
    input  o_enable_1,
    input  o_enable_2,
    input  o_enable_3
  );

  modport slave (
    input  i_sw,
    input  i_btn,
    output o_data,
    output o_enable_1,
    output o_enable_2,
    output o_enable_3
  );
endinterface

// File: rtl/alu_input_ctrl.sv
// Switch sync + button debounce/edge-detect front end for the ALU.
// ALU_INPUT_ONEHOT_EN: force enables one-hot, lowest index wins.
module alu_input_ctrl #(
  parameter int NB_DATA         = 8,
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_CNT          = 20
) (
  input logic              i_clk,
  input logic              i_reset,
  alu_input_ctrl_if.slave  bus
);

  localparam logic [NB_CNT-1:0] CNT_MAX =
    NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic [NB_DATA-1:0] sw_s1;
  logic [NB_DATA-1:0] sw_s2;
  logic [NB_DATA-1:0] data_q;
  logic [N_BTN-1:0]   btn_s1;
  logic [N_BTN-1:0]   btn_s2;
  logic [N_BTN-1:0]   stable;
  logic [N_BTN-1:0]   stable_d;
  logic [N_BTN-1:0]   pulse;
  logic [N_BTN-1:0]   pulse_sel;
  logic [N_BTN-1:0]   en_q;
  logic [NB_CNT-1:0]  cnt [N_BTN];

  // two-flop synchronizers plus the operand output register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      data_q <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= bus.i_sw;
      sw_s2  <= sw_s1;
      data_q <= sw_s2;
      btn_s1 <= bus.i_btn;
      btn_s2 <= btn_s1;
    end
  end

  // accept a new button level only after it holds for the full window
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stable <= '0;
      for (int k = 0; k < N_BTN; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_BTN; k++) begin
        if (btn_s2[k] == stable[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_MAX) begin
          stable[k] <= btn_s2[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // rising edge of the debounced level, optionally reduced to one-hot
  always_comb begin
    pulse     = stable & ~stable_d;
`ifdef ALU_INPUT_ONEHOT_EN
    pulse_sel = pulse & (~pulse + {{(N_BTN-1){1'b0}}, 1'b1});
`else
    pulse_sel = pulse;
`endif
  end

  // register the enable pulses so they last exactly one cycle
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stable_d <= '0;
      en_q     <= '0;
    end else begin
      stable_d <= stable;
      en_q     <= pulse_sel;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_enable_1 = en_q[0];
  assign bus.o_enable_2 = en_q[1];
  assign bus.o_enable_3 = en_q[2];

endmodule

// File: doc/alu_input_ctrl.md
Name: alu_input_ctrl

Overview:
- Front-end conditioning stage directly upstream of the ALU top.
- Takes raw board switches and push-buttons, synchronises them, and debounces the buttons.
- Emits a registered operand bus plus three single-cycle enable pulses that drive the ALU's i_data and i_enable_1/2/3 inputs.
- Guarantees each button press produces exactly one latch event in the ALU.

Parameters:
- NB_DATA, 8, width of switch bus and o_data
- N_BTN, 3, number of push-buttons; fixed at 3 for the ALU enables
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal range >= 2
- NB_CNT, 20, debounce counter width; must satisfy 2^NB_CNT >= DEBOUNCE_CYCLES

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-low reset (asserted when 0)
- i_sw  input  NB_DATA  raw, asynchronous switch levels
- i_btn  input  N_BTN  raw, asynchronous button levels, active-high; bit k maps to enable k+1
- o_data  output  NB_DATA  synchronised switch value, to ALU i_data
- o_enable_1  output  1  one-cycle pulse from i_btn[0]
- o_enable_2  output  1  one-cycle pulse from i_btn[1]
- o_enable_3  output  1  one-cycle pulse from i_btn[2]

Behaviour:
Reset:
- Reset is asynchronous and active-low.
- While i_reset=0, all synchronizer flops, stable levels, debounce counters, o_data, and all o_enable_* are cleared to 0.
- Release is synchronous to i_clk.

Switch path:
- 2-FF synchronizer, then one output register.
- o_data reflects an i_sw change at the 3rd rising edge after the change.
- No debounce on the switch path.

Button path, per bit, independent:
- 2-FF synchronizer produces sync_k.
- Debounce register stable_k and counter cnt_k.
- Each edge, if sync_k == stable_k: cnt_k <= 0.
- Each edge, if sync_k != stable_k and cnt_k < DEBOUNCE_CYCLES-1: cnt_k <= cnt_k+1.
- Each edge, if sync_k != stable_k and cnt_k == DEBOUNCE_CYCLES-1: stable_k <= sync_k and cnt_k <= 0.
- Any glitch that returns to stable_k before the count completes restarts the count from 0; stable_k does not change.
- Counter never wraps; it saturates by construction at DEBOUNCE_CYCLES-1.

Edge detect:
- Registered: o_enable_k <= stable_k & ~stable_k_d.
- Raw rise at cycle 0, held high: o_enable_k is high for exactly one cycle, beginning at edge DEBOUNCE_CYCLES+3.
- Falling edges generate no pulse, but release is debounced identically.
- Holding the button produces one pulse only.
- A new pulse requires a debounced release followed by a debounced press.

Timing relationships:
- o_data latency (3) is always less than enable latency (>= 5).
- Operand is therefore stable at the ALU before the enable pulse.

Boundary conditions:
- Button held high across reset release: stable_k starts at 0, so one pulse is emitted DEBOUNCE_CYCLES+3 edges after release.
- Simultaneous qualifying presses on several buttons: every pulse passes in the same cycle (see Optional Feature).
- Reset mid-count: counter cleared, and no pulse is emitted for the interrupted press.

Optional Feature:
Macro: ALU_INPUT_ONEHOT_EN
- Defined: enable outputs are forced one-hot with a lowest-index-wins rule.
  - If more than one pulse would fire in the same cycle, only the lowest-numbered enable is asserted.
  - Suppressed pulses are discarded, not deferred.
  - Adds no latency.
- Undefined: all coincident pulses are asserted together.

Test Plan:
1. Debounce latency, DEBOUNCE_CYCLES=4: reset low for 3 cycles, then release; raise i_btn[0] at cycle 10 and hold -> o_enable_1=1 only at edge 17; o_enable_2 and o_enable_3 stay 0; exactly one pulse over 50 held cycles.
2. Glitch reject, DEBOUNCE_CYCLES=4: i_btn[1] high for 3 cycles, then low -> no o_enable_2 pulse. Repeat with a 5-cycle high -> exactly one pulse.
3. Operand ordering: i_sw=8'hA5, then press i_btn[0] in the same cycle -> o_data=8'hA5 at edge 3, strictly before the o_enable_1 pulse. Set i_sw=8'h3C and press i_btn[1] -> o_data=8'h3C when o_enable_2 fires.
4. Release/re-press: press, hold 10 cycles, release 10 cycles, press again -> exactly two o_enable_3 pulses, no pulse on release.
5. Reset mid-operation: press i_btn[2] and assert i_reset=0 at count 2 -> all outputs 0 immediately, asynchronously. Button still held after release -> single pulse at DEBOUNCE_CYCLES+3 edges after release.
6. Simultaneous presses: i_btn=3'b111 in one cycle -> without macro, all three enables are high in the same cycle; with ALU_INPUT_ONEHOT_EN, only o_enable_1 is high.
